// File: rtl/msrv32_pkg.sv
// rtl/msrv32_pkg.sv - shared writeback encodings and scheduler state type
package msrv32_pkg;

  localparam logic [2:0] WB_ALU        = 3'b000;
  localparam logic [2:0] WB_LU         = 3'b001;
  localparam logic [2:0] WB_IMM        = 3'b010;
  localparam logic [2:0] WB_IADDER_OUT = 3'b011;
  localparam logic [2:0] WB_CSR        = 3'b100;
  localparam logic [2:0] WB_PC_PLUS    = 3'b101;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    LOAD_WB   = 2'd2
  } wb_state_e;

  // x0 is hardwired to zero, so a write to it is never issued
  function automatic logic rf_write_ok(input logic wr_en, input logic [4:0] rd);
    return wr_en & (rd != 5'd0);
  endfunction

endpackage

// File: rtl/msrv32_load_wait_ctr.sv
// rtl/msrv32_load_wait_ctr.sv - load wait cycle counter with clear, enable and terminal flag
module msrv32_load_wait_ctr #(
  parameter int CNT_W         = 4,
  parameter int MAX_LOAD_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Terminal on the last permitted wait cycle so the abandon happens after MAX_LOAD_WAIT cycles
  assign terminal = (count == CNT_W'(MAX_LOAD_WAIT - 1));

endmodule

// File: rtl/msrv32_wb_sched_unit.sv
// rtl/msrv32_wb_sched_unit.sv - writeback scheduler: registers wb select/rd/write enable,
// stalls on multi-cycle loads, aborts on flush or timeout, counts regfile writes
module msrv32_wb_sched_unit
  import msrv32_pkg::*;
#(
  parameter int MAX_LOAD_WAIT = 15,
  parameter int CNT_W         = 4,
  parameter int RET_W         = 16
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_in,
  input  logic             issue_valid_in,
  input  logic [2:0]       wb_mux_sel_in,
  input  logic [4:0]       rd_addr_in,
  input  logic             rf_wr_en_in,
  input  logic             is_load_in,
  input  logic             flush_in,
  input  logic             dmem_ready_in,
  output logic [2:0]       wb_mux_sel_reg_out,
  output logic [4:0]       rd_addr_reg_out,
  output logic             rf_wr_en_out,
  output logic             stall_out,
  output logic             load_timeout_out,
  output logic [RET_W-1:0] wb_count_out
);

  wb_state_e        state;
  logic             saved_wr_en;
  logic             accept;
  logic             wr_en_nxt;
  logic             ctr_clear;
  logic             ctr_enable;
  logic             ctr_terminal;
  logic [CNT_W-1:0] wait_count;

  assign accept = issue_valid_in & ~flush_in & (state != LOAD_WAIT);

  // Next-cycle write strobe, shared by the output register and the retire counter
  always_comb begin
    wr_en_nxt = 1'b0;
    if (!flush_in) begin
      if (state == LOAD_WAIT) begin
        wr_en_nxt = dmem_ready_in & saved_wr_en;
      end else if (accept && !is_load_in) begin
        wr_en_nxt = rf_write_ok(rf_wr_en_in, rd_addr_in);
      end
    end
  end

  assign ctr_clear  = flush_in | (state != LOAD_WAIT);
  assign ctr_enable = (state == LOAD_WAIT) & ~dmem_ready_in;

  msrv32_load_wait_ctr #(
    .CNT_W        (CNT_W),
    .MAX_LOAD_WAIT(MAX_LOAD_WAIT)
  ) u_load_wait_ctr (
    .clk     (ms_riscv32_mp_clk_in),
    .rst     (ms_riscv32_mp_rst_in),
    .clear   (ctr_clear),
    .enable  (ctr_enable),
    .count   (wait_count),
    .terminal(ctr_terminal)
  );

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state              <= IDLE;
      wb_mux_sel_reg_out <= WB_ALU;
      rd_addr_reg_out    <= 5'd0;
      rf_wr_en_out       <= 1'b0;
      stall_out          <= 1'b0;
      load_timeout_out   <= 1'b0;
      wb_count_out       <= '0;
      saved_wr_en        <= 1'b0;
    end else begin
      rf_wr_en_out     <= wr_en_nxt;
      wb_count_out     <= wb_count_out + RET_W'(wr_en_nxt);
      load_timeout_out <= 1'b0;
      if (flush_in) begin
        state     <= IDLE;
        stall_out <= 1'b0;
      end else begin
        case (state)
          LOAD_WAIT: begin
            if (dmem_ready_in) begin
              state     <= LOAD_WB;
              stall_out <= 1'b0;
            end else if (ctr_terminal) begin
              load_timeout_out <= 1'b1;
              state            <= IDLE;
              stall_out        <= 1'b0;
            end
          end
          default: begin
            stall_out <= 1'b0;
            state     <= IDLE;
            if (accept) begin
              rd_addr_reg_out <= rd_addr_in;
              if (is_load_in) begin
                wb_mux_sel_reg_out <= WB_LU;
                saved_wr_en        <= rf_write_ok(rf_wr_en_in, rd_addr_in);
                state              <= LOAD_WAIT;
                stall_out          <= 1'b1;
              end else begin
                wb_mux_sel_reg_out <= wb_mux_sel_in;
              end
            end
          end
        endcase
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^wait_count;

endmodule
